hazard_forward_unit: RTL
========================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5: register-address width.
REQ-002 SHALL have parameter CNT_W, default 16: stall-cycle counter width.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255: maximum memory-wait cycles before abort.
REQ-004 Ports SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_src1, id_src2  in  REG_AW  ID-stage source register numbers.
- id_use_src1, id_use_src2  in  1  source actually read (immediate or branch decode clears it).
- exe_dest, mem_dest  in  REG_AW  destinations of instructions in EXE and MEM.
- exe_wb_en, mem_wb_en  in  1  those instructions write back.
- exe_mem_rd  in  1  EXE instruction is a load.
- mem_req  in  1  MEM stage starts or holds a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- stall_if_id  out  1  hold PC and the IF/ID register.
- flush_id_ex  out  1  load a bubble into ID/EX.
- freeze_pipe  out  1  hold every pipeline register.
- fwd_a, fwd_b  out  2  registered EX operand select: 00 regfile, 01 MEM-stage result, 10 WB-stage result.
- mem_timeout  out  1  sticky memory-wait abort flag.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Function
REQ-005 A source SHALL match a destination only when the source is in use, the destination's wb_en is 1, both addresses are equal, and the source is nonzero; register 0 never causes a hazard.
REQ-006 Load-use: any ID source matching exe_dest with exe_mem_rd=1 SHALL combinationally assert stall_if_id=1 and flush_id_ex=1 for that cycle.
REQ-007 On each clock edge with freeze_pipe=0, fwd_a and fwd_b SHALL be updated.
REQ-008 The update SHALL load 00 when flush_id_ex=1.
REQ-009 Otherwise the update SHALL load 01 on an EXE match, else 10 on a MEM match, else 00; EXE has priority when both match.
REQ-010 With freeze_pipe=1, fwd_a and fwd_b SHALL hold their values.
REQ-011 The memory-wait FSM SHALL have the states IDLE and WAIT.
REQ-012 IDLE SHALL go to WAIT on mem_req=1 with mem_ready=0.
REQ-013 WAIT SHALL go to IDLE on mem_ready=1 or when the wait counter reaches MEM_TIMEOUT.
REQ-014 The wait counter SHALL clear in IDLE and increment each WAIT cycle.
REQ-015 freeze_pipe SHALL equal (mem_req & ~mem_ready) | (state==WAIT & ~mem_ready), so it drops in the same cycle that mem_ready rises.
REQ-016 Leaving WAIT on timeout SHALL set mem_timeout=1, which holds until reset; freeze_pipe SHALL be 0 in the exit cycle.
REQ-017 When freeze_pipe=1 and a load-use hazard coexist, freeze SHALL dominate: stall_if_id=1 and flush_id_ex=0.
REQ-018 stall_count SHALL increment on every edge where stall_if_id|freeze_pipe=1 and SHALL saturate at all ones without wrapping.
REQ-019 In IDLE with no hazard, stall_if_id, flush_id_ex and freeze_pipe SHALL be 0.

Reset
REQ-020 rst_n=0 SHALL asynchronously force state=IDLE, wait counter=0, fwd_a=fwd_b=00, mem_timeout=0 and stall_count=0.
REQ-021 Reset asserted mid-WAIT SHALL abort the wait immediately; after release, combinational outputs SHALL follow the inputs from the first cycle.

Configuration
REQ-022 The macro HAZARD_FORWARDING_EN SHALL select the operating mode.
REQ-023 With HAZARD_FORWARDING_EN defined, behaviour SHALL be as described in REQ-006 through REQ-010.
REQ-024 With HAZARD_FORWARDING_EN undefined, fwd_a and fwd_b SHALL be constant 00.
REQ-025 With HAZARD_FORWARDING_EN undefined, any ID source matching exe_dest or mem_dest SHALL assert stall_if_id=1 and flush_id_ex=1 (freeze rules unchanged).

Verification
REQ-026 (forwarding on) id_src1=3, exe_dest=3, exe_wb_en=1, exe_mem_rd=0 -> no stall; fwd_a=01 after the edge.
REQ-027 (forwarding on) id_src2=7, exe_dest=7, exe_mem_rd=1, exe_wb_en=1 -> stall_if_id=flush_id_ex=1 for one cycle, fwd_b=00; next cycle mem_dest=7, mem_wb_en=1 -> fwd_b=10.
REQ-028 id_src1=0, exe_dest=0, exe_wb_en=1, exe_mem_rd=1 -> no stall; fwd_a=00.
REQ-029 mem_req=1, mem_ready=0 for 4 cycles then 1 -> freeze_pipe=1 for exactly 4 cycles, fwd_a/fwd_b held, stall_count=4.
REQ-030 MEM_TIMEOUT=3, mem_ready held at 0 -> mem_timeout=1 after the timeout, FSM back in IDLE, flag sticky until rst_n=0.
REQ-031 (forwarding off) id_src1=5, mem_dest=5, mem_wb_en=1 -> stall_if_id=flush_id_ex=1, fwd_a=00; CNT_W=2 with 5 stalled cycles -> stall_count=3.

Source files
------------

// File: rtl/hazard_forward_unit_if.sv
// Pipeline hazard/forwarding bus: ID-stage sources, EXE/MEM destinations,
// data-memory handshake, and the resulting stall/flush/freeze/forward controls.
interface hazard_forward_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_use_src1;
  logic              id_use_src2;
  logic [REG_AW-1:0] exe_dest;
  logic [REG_AW-1:0] mem_dest;
  logic              exe_wb_en;
  logic              mem_wb_en;
  logic              exe_mem_rd;
  logic              mem_req;
  logic              mem_ready;
  logic              stall_if_id;
  logic              flush_id_ex;
  logic              freeze_pipe;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_timeout;
  logic [CNT_W-1:0]  stall_count;

  // Pipeline side: supplies stage information, consumes control outputs.
  modport master (
    output id_src1, id_src2, id_use_src1, id_use_src2,
    output exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_rd,
    output mem_req, mem_ready,
    input  stall_if_id, flush_id_ex, freeze_pipe,
    input  fwd_a, fwd_b, mem_timeout, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_src1, id_src2, id_use_src1, id_use_src2,
    input  exe_dest, mem_dest, exe_wb_en, mem_wb_en, exe_mem_rd,
    input  mem_req, mem_ready,
    output stall_if_id, flush_id_ex, freeze_pipe,
    output fwd_a, fwd_b, mem_timeout, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a 5-stage pipeline, plus a
// memory-wait FSM that freezes the pipe while data memory is busy and aborts
// (sticky mem_timeout) after MEM_TIMEOUT wait cycles.
// Build option: define HAZARD_FORWARDING_EN to enable EX operand forwarding;
// without it every RAW dependency on EXE or MEM stalls and fwd_a/fwd_b are 00.
module hazard_forward_unit #(
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_unit_if.slave bus
);

  localparam int WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MEM_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t             state_reg, state_next;
  logic [WCNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic               timeout_reg;
  logic [CNT_W-1:0]   stall_cnt_reg;
  logic               freeze;
  logic               timeout_exit;
  logic               hazard;
  logic               exe_hit1, exe_hit2, mem_hit1, mem_hit2;

  // Register 0 is hardwired, so it never creates a dependency.
  function automatic logic src_match(input logic [REG_AW-1:0] src, input logic use_src,
                                     input logic [REG_AW-1:0] dest, input logic wb_en);
    return use_src && wb_en && (src == dest) && (src != '0);
  endfunction

  assign exe_hit1 = src_match(bus.id_src1, bus.id_use_src1, bus.exe_dest, bus.exe_wb_en);
  assign exe_hit2 = src_match(bus.id_src2, bus.id_use_src2, bus.exe_dest, bus.exe_wb_en);
  assign mem_hit1 = src_match(bus.id_src1, bus.id_use_src1, bus.mem_dest, bus.mem_wb_en);
  assign mem_hit2 = src_match(bus.id_src2, bus.id_use_src2, bus.mem_dest, bus.mem_wb_en);

`ifdef HAZARD_FORWARDING_EN
  // Only a load in EXE cannot be forwarded in time.
  assign hazard = bus.exe_mem_rd & (exe_hit1 | exe_hit2);
`else
  // No bypass paths: any pending writer of a source must drain first.
  assign hazard = exe_hit1 | exe_hit2 | mem_hit1 | mem_hit2;
  logic unused_ok;
  assign unused_ok = bus.exe_mem_rd;
`endif

  // Memory-wait next state, wait counter and freeze; a timeout exit unfreezes.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = '0;
    timeout_exit  = 1'b0;
    freeze        = bus.mem_req & ~bus.mem_ready;
    case (state_reg)
      IDLE: begin
        if (bus.mem_req && !bus.mem_ready) state_next = WAIT;
      end
      WAIT: begin
        freeze = ~bus.mem_ready;
        if (bus.mem_ready) begin
          state_next = IDLE;
        end else if (wait_cnt_reg == WAIT_LIMIT) begin
          state_next   = IDLE;
          timeout_exit = 1'b1;
          freeze       = 1'b0;
        end else begin
          wait_cnt_next = wait_cnt_reg + WCNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (timeout_exit) timeout_reg <= 1'b1;
    end
  end

  // Saturating count of cycles the pipeline did not advance normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if ((hazard || freeze) && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

`ifdef HAZARD_FORWARDING_EN
  logic [1:0] fwd_a_reg, fwd_b_reg;

  // Operand selects travel with the instruction into EX; a bubble gets 00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_reg <= 2'b00;
      fwd_b_reg <= 2'b00;
    end else if (!freeze) begin
      if (hazard) begin
        fwd_a_reg <= 2'b00;
        fwd_b_reg <= 2'b00;
      end else begin
        fwd_a_reg <= exe_hit1 ? 2'b01 : (mem_hit1 ? 2'b10 : 2'b00);
        fwd_b_reg <= exe_hit2 ? 2'b01 : (mem_hit2 ? 2'b10 : 2'b00);
      end
    end
  end

  assign bus.fwd_a = fwd_a_reg;
  assign bus.fwd_b = fwd_b_reg;
`else
  assign bus.fwd_a = 2'b00;
  assign bus.fwd_b = 2'b00;
`endif

  // Freeze outranks the load-use bubble: hold everything, insert nothing.
  assign bus.stall_if_id = hazard;
  assign bus.flush_id_ex = hazard & ~freeze;
  assign bus.freeze_pipe = freeze;
  assign bus.mem_timeout = timeout_reg;
  assign bus.stall_count = stall_cnt_reg;

endmodule
